alu_result_stage: RTL and testbench

//  Registered stage directly downstream of the arithmetic unit. Captures result + extension bits,

---
 rtl/alu_result_stage.sv | 163 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Result register stage behind the arithmetic unit: derives C/Z/N(/P) status on push and buffers
// results in a 2-entry FIFO towards writeback. Optional parity flag: define ALU_RESULT_PARITY_EN.
package alu_result_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_INC = 4'd2,
        OP_DEC = 4'd3,
        OP_SHL = 4'd4,
        OP_SHR = 4'd5,
        OP_MUL = 4'd6,
        OP_DIV = 4'd7
    } enum_alu_opcode_t;
endpackage

module alu_result_stage
    import alu_result_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int REG_ADDR_W = 3,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [1:0]            in_ext,
    input  enum_alu_opcode_t      in_opcode,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_flag_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  status_c,
    output logic                  status_z,
    output logic                  status_n,
    output logic                  status_p,
    output logic                  carry_fb
);
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [DATA_WIDTH-1:0] data_mem_q [2];
    logic [DATA_WIDTH-1:0] data_mem_d [2];
    logic [REG_ADDR_W-1:0] dest_mem_q [2];
    logic [REG_ADDR_W-1:0] dest_mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [REG_ADDR_W-1:0] out_dest_q, out_dest_d;
    logic                  status_c_q, status_c_d;
    logic                  status_z_q, status_z_d;
    logic                  status_n_q, status_n_d;
    logic                  push, pop, flag_upd, c_new;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign flag_upd  = push & in_flag_we & ~flush;

    always_comb begin
        c_new = 1'b0;
        case (in_opcode)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL, OP_SHR: c_new = in_ext[0];
            OP_MUL:                                         c_new = |in_ext;
            default:                                        c_new = 1'b0;
        endcase
    end

    always_comb begin
        data_mem_d = data_mem_q;
        dest_mem_d = dest_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        status_c_d = status_c_q;
        status_z_d = status_z_q;
        status_n_d = status_n_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                data_mem_d[wr_ptr_q] = in_result;
                dest_mem_d[wr_ptr_q] = in_dest;
                wr_ptr_d             = ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        if (flag_upd) begin
            status_c_d = c_new;
            status_z_d = (in_result == '0);
            status_n_d = in_result[DATA_WIDTH-1];
        end
        // Output register tracks the next head so out_* hold the last value once empty.
        out_data_d = (count_d != 2'd0) ? data_mem_d[rd_ptr_d] : out_data_q;
        out_dest_d = (count_d != 2'd0) ? dest_mem_d[rd_ptr_d] : out_dest_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_mem_q[i] <= '0;
                dest_mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            out_data_q <= '0;
            out_dest_q <= '0;
            status_c_q <= 1'b0;
            status_z_q <= 1'b0;
            status_n_q <= 1'b0;
        end else begin
            data_mem_q <= data_mem_d;
            dest_mem_q <= dest_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            out_dest_q <= out_dest_d;
            status_c_q <= status_c_d;
            status_z_q <= status_z_d;
            status_n_q <= status_n_d;
        end
    end

`ifdef ALU_RESULT_PARITY_EN
    logic status_p_q, status_p_d;

    always_comb begin
        status_p_d = status_p_q;
        if (flag_upd)
            status_p_d = ~^in_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_p_q <= 1'b0;
        else        status_p_q <= status_p_d;
    end

    assign status_p = status_p_q;
`else
    assign status_p = 1'b0;
`endif

    assign out_data = out_data_q;
    assign out_dest = out_dest_q;
    assign status_c = status_c_q;
    assign status_z = status_z_q;
    assign status_n = status_n_q;
    assign carry_fb = status_c_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, flag derivation, backpressure, streaming, flush.
module tb_alu_result_stage;
    import alu_result_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_result = '0;
    logic [1:0]       in_ext = '0;
    enum_alu_opcode_t in_opcode = OP_ADD;
    logic [2:0]       in_dest = '0;
    logic             in_flag_we = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [2:0]       out_dest;
    logic             status_c, status_z, status_n, status_p, carry_fb;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ALU_RESULT_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    alu_result_stage #(.DATA_WIDTH(16), .REG_ADDR_W(3), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_ext(in_ext),
        .in_opcode(in_opcode), .in_dest(in_dest), .in_flag_we(in_flag_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
        .status_c(status_c), .status_z(status_z), .status_n(status_n), .status_p(status_p),
        .carry_fb(carry_fb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input enum_alu_opcode_t op, input logic [15:0] res, input logic [1:0] ext,
                         input logic [2:0] dest, input logic we);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_result  = res;
        in_ext     = ext;
        in_dest    = dest;
        in_flag_we = we;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if ({out_valid, in_ready, status_c, status_z, status_n, status_p, carry_fb} !== 7'b0100000) begin
            n_err++; $display("FAIL reset_init ctl=%b want 0100000", {out_valid, in_ready, status_c, status_z, status_n, status_p, carry_fb});
        end
        n_cmp++; if ({out_data, out_dest} !== 19'h0) begin
            n_err++; $display("FAIL reset_init_data got %h/%h want 0/0", out_data, out_dest);
        end
        tick();
        rst_n = 1'b1;
        // fill both entries with a flag-updating op, then reset mid-stream
        drive(OP_ADD, 16'h0000, 2'b01, 3'd1, 1'b1);
        tick();
        drive(OP_ADD, 16'h0101, 2'b01, 3'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, in_ready, status_c} !== 3'b101) begin
            n_err++; $display("FAIL reset_prefill got v/r/c=%b want 101", {out_valid, in_ready, status_c});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, in_ready, status_c, status_z, status_n, status_p, carry_fb} !== 7'b0100000) begin
            n_err++; $display("FAIL reset_mid ctl=%b want 0100000", {out_valid, in_ready, status_c, status_z, status_n, status_p, carry_fb});
        end
        n_cmp++; if ({out_data, out_dest} !== 19'h0) begin
            n_err++; $display("FAIL reset_mid_data got %h/%h want 0/0", out_data, out_dest);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_flags();
        out_ready = 1'b0;
        drive(OP_ADD, 16'h0000, 2'b01, 3'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({status_c, status_z, status_n, carry_fb} !== 4'b1101) begin
            n_err++; $display("FAIL add_flags czn_fb=%b want 1101", {status_c, status_z, status_n, carry_fb});
        end
        n_cmp++; if ({out_valid, out_data, out_dest} !== {1'b1, 16'h0000, 3'd3}) begin
            n_err++; $display("FAIL add_out got v=%b %h/%0d want 1 0000/3", out_valid, out_data, out_dest);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL add_pop out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(OP_SUB, 16'h1111, 2'b00, 3'd1, 1'b0);
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_one in_ready=%b want 1", in_ready);
        end
        drive(OP_SUB, 16'h2222, 2'b00, 3'd2, 1'b0);
        tick();
        n_cmp++; if ({in_ready, out_data} !== {1'b0, 16'h1111}) begin
            n_err++; $display("FAIL bp_full rdy=%b head=%h want 0 1111", in_ready, out_data);
        end
        drive(OP_SUB, 16'h3333, 2'b00, 3'd3, 1'b0);
        tick();
        n_cmp++; if ({in_ready, out_data} !== {1'b0, 16'h1111}) begin
            n_err++; $display("FAIL bp_hold rdy=%b head=%h want 0 1111", in_ready, out_data);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if ({out_valid, in_ready, out_data, out_dest} !== {2'b11, 16'h2222, 3'd2}) begin
            n_err++; $display("FAIL bp_popA v/r=%b head=%h/%0d want 11 2222/2", {out_valid, in_ready}, out_data, out_dest);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_data, out_dest} !== {1'b1, 16'h3333, 3'd3}) begin
            n_err++; $display("FAIL bp_popB v=%b head=%h/%0d want 1 3333/3", out_valid, out_data, out_dest);
        end
        tick();
        out_ready = 1'b0;
        n_cmp++; if ({out_valid, out_data} !== {1'b0, 16'h3333}) begin
            n_err++; $display("FAIL bp_empty v=%b data=%h want 0 3333", out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(OP_INC, 16'hA000, 2'b00, 3'd0, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(OP_INC, 16'hA000 + 16'(i), 2'b00, 3'(i), 1'b0);
            tick();
            n_cmp++; if ({out_valid, in_ready, out_data, out_dest} !== {2'b11, 16'hA000 + 16'(i), 3'(i)}) begin
                n_err++; $display("FAIL b2b_%0d v/r=%b head=%h/%0d want 11 %h/%0d", i, {out_valid, in_ready},
                                  out_data, out_dest, 16'hA000 + 16'(i), i % 8);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_drain out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_mul_div();
        out_ready = 1'b1;
        drive(OP_MUL, 16'h8000, 2'b10, 3'd1, 1'b1);
        tick();
        n_cmp++; if ({status_c, status_z, status_n, carry_fb} !== 4'b1011) begin
            n_err++; $display("FAIL mul_flags czn_fb=%b want 1011", {status_c, status_z, status_n, carry_fb});
        end
        drive(OP_DIV, 16'h0003, 2'b11, 3'd2, 1'b1);
        tick();
        n_cmp++; if ({status_c, status_z, status_n, status_p} !== {3'b000, PEN}) begin
            n_err++; $display("FAIL div_flags cznp=%b want 000%b", {status_c, status_z, status_n, status_p}, PEN);
        end
        drive(OP_INC, 16'h0001, 2'b00, 3'd3, 1'b1);
        tick();
        n_cmp++; if ({status_c, status_z, status_n, status_p} !== 4'b0000) begin
            n_err++; $display("FAIL inc_flags cznp=%b want 0000", {status_c, status_z, status_n, status_p});
        end
        drive(OP_SUB, 16'h0000, 2'b01, 3'd4, 1'b0);
        tick();
        n_cmp++; if ({status_c, status_z, status_n, status_p} !== 4'b0000) begin
            n_err++; $display("FAIL nowe_flags cznp=%b want 0000", {status_c, status_z, status_n, status_p});
        end
        drive(enum_alu_opcode_t'(4'hF), 16'h0000, 2'b11, 3'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({status_c, status_z, status_n, status_p} !== {3'b010, PEN}) begin
            n_err++; $display("FAIL unk_flags cznp=%b want 010%b", {status_c, status_z, status_n, status_p}, PEN);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(OP_ADD, 16'hFFFF, 2'b01, 3'd5, 1'b1);
        tick();
        drive(OP_ADD, 16'h1234, 2'b00, 3'd6, 1'b0);
        tick();
        drive(OP_ADD, 16'h0000, 2'b00, 3'd7, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, in_ready, out_data} !== {2'b01, 16'hFFFF}) begin
            n_err++; $display("FAIL flush_full v/r=%b data=%h want 01 FFFF", {out_valid, in_ready}, out_data);
        end
        n_cmp++; if ({status_c, status_z, status_n, status_p} !== {3'b101, PEN}) begin
            n_err++; $display("FAIL flush_full_flags cznp=%b want 101%b", {status_c, status_z, status_n, status_p}, PEN);
        end
        drive(OP_SUB, 16'h0042, 2'b00, 3'd1, 1'b0);
        tick();
        // push that would otherwise be accepted and clear carry/set zero
        drive(OP_SUB, 16'h0000, 2'b00, 3'd2, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, in_ready, status_c, status_z, status_n} !== 5'b01101) begin
            n_err++; $display("FAIL flush_push v/r/czn=%b want 01101", {out_valid, in_ready, status_c, status_z, status_n});
        end
        drive(OP_SUB, 16'h0055, 2'b00, 3'd6, 1'b0);
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_data, out_dest} !== {1'b1, 16'h0055, 3'd6}) begin
            n_err++; $display("FAIL flush_after v=%b head=%h/%0d want 1 0055/6", out_valid, out_data, out_dest);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_drain out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add_flags();
        test_backpressure();
        test_back_to_back();
        test_mul_div();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
